// File: rtl/icache_pkg.sv
// Shared widths and address-field ranges for the instruction cache, plus the
// fill FSM state type. Each macro is defined only if the including build has not already set it.
`ifndef ADDR_WID
`define ADDR_WID 32
`endif
`ifndef MEM_CTRL_IF_DATA_LEN
`define MEM_CTRL_IF_DATA_LEN 64
`endif
`ifndef IF_DATA_WID
`define IF_DATA_WID 512
`endif
`ifndef ICACHE_LINES
`define ICACHE_LINES 16
`endif
`ifndef ICACHE_INDEX_RANGE
`define ICACHE_INDEX_RANGE 9:6
`endif
`ifndef ICACHE_TAG_RANGE
`define ICACHE_TAG_RANGE 31:10
`endif

package icache_pkg;
    localparam int ADDR_WID     = `ADDR_WID;
    localparam int IF_DATA_WID  = `IF_DATA_WID;
    localparam int LINE_BYTES   = `MEM_CTRL_IF_DATA_LEN;
    localparam int ICACHE_LINES = `ICACHE_LINES;
    localparam int INDEX_WID    = $clog2(ICACHE_LINES);
    localparam int OFFSET_WID   = $clog2(LINE_BYTES);
    localparam int TAG_WID      = ADDR_WID - INDEX_WID - OFFSET_WID;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } state_t;
endpackage

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with a single outstanding line fill.
// Lookup is purely combinational; fills land in the arrays on the mem_done edge.
//
//  state    | meaning
//  IDLE     | serving hits; a requested miss starts a line fill
//  WAIT_MEM | fill outstanding, mem_en/mem_pc held until mem_done
module icache
    import icache_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic                   fetch_en,
    input  logic [ADDR_WID-1:0]    fetch_pc,
    output logic                   hit,
    output logic [31:0]            inst,
    output logic                   mem_en,
    output logic [ADDR_WID-1:0]    mem_pc,
    input  logic                   mem_done,
    input  logic [IF_DATA_WID-1:0] mem_data
);
    state_t                   state, state_nxt;
    logic                     mem_en_nxt;
    logic [ADDR_WID-1:0]      mem_pc_nxt;
    logic                     fill_we;

    logic [ICACHE_LINES-1:0]  valid;
    logic [TAG_WID-1:0]       tag_arr  [ICACHE_LINES];
    logic [IF_DATA_WID-1:0]   data_arr [ICACHE_LINES];

    logic [INDEX_WID-1:0]     fetch_idx;
    logic [TAG_WID-1:0]       fetch_tag;
    logic [3:0]               fetch_word;
    logic [INDEX_WID-1:0]     fill_idx;
    logic                     unused_pc_bits;

    assign fetch_idx      = fetch_pc[`ICACHE_INDEX_RANGE];
    assign fetch_tag      = fetch_pc[`ICACHE_TAG_RANGE];
    assign fetch_word     = fetch_pc[5:2];
    assign fill_idx       = mem_pc[`ICACHE_INDEX_RANGE];
    assign unused_pc_bits = ^fetch_pc[1:0];

    assign hit  = valid[fetch_idx] && (tag_arr[fetch_idx] == fetch_tag);
    assign inst = data_arr[fetch_idx][{fetch_word, 5'b0} +: 32];

    always_comb begin
        state_nxt  = state;
        mem_en_nxt = mem_en;
        mem_pc_nxt = mem_pc;
        fill_we    = 1'b0;
        case (state)
            IDLE: begin
                if (fetch_en && !hit) begin
                    state_nxt  = WAIT_MEM;
                    mem_en_nxt = 1'b1;
                    mem_pc_nxt = {fetch_pc[ADDR_WID-1:OFFSET_WID], {OFFSET_WID{1'b0}}};
                end
            end
            WAIT_MEM: begin
                if (mem_done) begin
                    fill_we    = 1'b1;
                    state_nxt  = IDLE;
                    mem_en_nxt = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            mem_en <= 1'b0;
            mem_pc <= '0;
            valid  <= '0;
        end else if (rdy) begin
            state  <= state_nxt;
            mem_en <= mem_en_nxt;
            mem_pc <= mem_pc_nxt;
            if (fill_we) valid[fill_idx] <= 1'b1;
        end
    end

    // Tag/data storage carries no reset; valid bits alone qualify a line.
    always_ff @(posedge clk) begin
        if (!rst && rdy && fill_we) begin
            tag_arr[fill_idx]  <= mem_pc[`ICACHE_TAG_RANGE];
            data_arr[fill_idx] <= mem_data;
        end
    end
endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: a bench-side memory model serves fills and a
// queue of expected fill addresses is checked against mem_pc as each fill is issued.
module tb_icache;
    import icache_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst, rdy, fetch_en, mem_done;
    logic [ADDR_WID-1:0]    fetch_pc;
    logic                   hit, mem_en;
    logic [31:0]            inst;
    logic [ADDR_WID-1:0]    mem_pc;
    logic [IF_DATA_WID-1:0] mem_data;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_fill_q[$];

    always #5 clk = ~clk;

    icache dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .fetch_en (fetch_en),
        .fetch_pc (fetch_pc),
        .hit      (hit),
        .inst     (inst),
        .mem_en   (mem_en),
        .mem_pc   (mem_pc),
        .mem_done (mem_done),
        .mem_data (mem_data)
    );

    // Memory contents: byte i of a line is i plus a term from the line's tag/index.
    function automatic logic [IF_DATA_WID-1:0] line_of(input logic [31:0] pc);
        logic [IF_DATA_WID-1:0] l;
        int b;
        for (int i = 0; i < LINE_BYTES; i++) begin
            b = i + 17 * int'(pc[17:10]) + 101 * int'(pc[9:6]);
            l[8*i +: 8] = b[7:0];
        end
        return l;
    endfunction

    function automatic logic [31:0] exp_inst(input logic [31:0] pc);
        logic [IF_DATA_WID-1:0] l;
        l = line_of(pc);
        return l[32*int'(pc[5:2]) +: 32];
    endfunction

    task automatic wait_mem_en(input string name);
        int k = 0;
        @(negedge clk);
        while (!mem_en && k < 20) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (mem_en !== 1'b1) begin
            n_fail++;
            $display("FAIL %s mem_en_timeout: got %b want 1", name, mem_en);
        end
    endtask

    // Called at a negedge with mem_en high; returns just after the done edge.
    task automatic serve_fill(input string name);
        logic [31:0] exp_pc;
        exp_pc = '0;
        n_tests++;
        if (exp_fill_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s fill_unexpected: mem_pc %h with empty queue", name, mem_pc);
        end else begin
            exp_pc = exp_fill_q.pop_front();
            if (mem_pc !== exp_pc) begin
                n_fail++;
                $display("FAIL %s fill_addr: got %h want %h", name, mem_pc, exp_pc);
            end
        end
        mem_data = line_of(exp_pc);
        mem_done = 1'b1;
        @(posedge clk);
        #1 mem_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; fetch_en = 1'b0; fetch_pc = '0;
        mem_done = 1'b0; mem_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (hit !== 1'b0 || mem_en !== 1'b0 || mem_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: hit=%b mem_en=%b mem_pc=%h want 0/0/0", hit, mem_en, mem_pc);
        end
    endtask

    task automatic test_cold_miss();
        fetch_en = 1'b1; fetch_pc = 32'h0000_0004;
        exp_fill_q.push_back(32'h0);
        #1;
        n_tests++;
        if (hit !== 1'b0) begin
            n_fail++; $display("FAIL cold_miss_hit: got %b want 0", hit);
        end
        @(negedge clk);
        n_tests++;
        if (mem_en !== 1'b1) begin
            n_fail++; $display("FAIL cold_miss_mem_en_latency: got %b want 1", mem_en);
        end
        serve_fill("cold_miss");
        @(negedge clk);
        n_tests++;
        if (hit !== 1'b1 || inst !== 32'h0706_0504 || mem_en !== 1'b0) begin
            n_fail++;
            $display("FAIL cold_miss_after_fill: hit=%b inst=%h mem_en=%b want 1/07060504/0", hit, inst, mem_en);
        end
    endtask

    task automatic test_same_line_hit();
        fetch_pc = 32'h0000_003C;
        #1;
        n_tests++;
        if (hit !== 1'b1 || inst !== 32'h3F3E_3D3C) begin
            n_fail++; $display("FAIL same_line_hit: hit=%b inst=%h want 1/3f3e3d3c", hit, inst);
        end
        repeat (2) @(negedge clk);
        n_tests++;
        if (mem_en !== 1'b0) begin
            n_fail++; $display("FAIL same_line_no_fill: mem_en=%b want 0", mem_en);
        end
        fetch_en = 1'b0;
    endtask

    task automatic test_conflict();
        fetch_en = 1'b1; fetch_pc = 32'h0000_0408;
        exp_fill_q.push_back(32'h0000_0400);
        #1;
        n_tests++;
        if (hit !== 1'b0) begin
            n_fail++; $display("FAIL conflict_miss: hit=%b want 0", hit);
        end
        wait_mem_en("conflict");
        serve_fill("conflict");
        fetch_en = 1'b0;
        @(negedge clk);
        n_tests++;
        if (hit !== 1'b1 || inst !== exp_inst(32'h0000_0408)) begin
            n_fail++;
            $display("FAIL conflict_new_line: hit=%b inst=%h want 1/%h", hit, inst, exp_inst(32'h0000_0408));
        end
        fetch_pc = 32'h0000_0000;
        #1;
        n_tests++;
        if (hit !== 1'b0) begin
            n_fail++; $display("FAIL conflict_evicted: hit=%b want 0", hit);
        end
    endtask

    task automatic test_flush();
        fetch_en = 1'b1; fetch_pc = 32'h0000_0000;
        exp_fill_q.push_back(32'h0);
        wait_mem_en("flush");
        fetch_pc = 32'h0000_0100;
        exp_fill_q.push_back(32'h0000_0100);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (mem_en !== 1'b1 || mem_pc !== 32'h0) begin
                n_fail++;
                $display("FAIL flush_hold_%0d: mem_en=%b mem_pc=%h want 1/00000000", i, mem_en, mem_pc);
            end
        end
        serve_fill("flush_old");
        @(negedge clk);
        n_tests++;
        if (mem_en !== 1'b0) begin
            n_fail++; $display("FAIL flush_idle_gap: mem_en=%b want 0", mem_en);
        end
        fetch_pc = 32'h0000_0010;
        #1;
        n_tests++;
        if (hit !== 1'b1 || inst !== exp_inst(32'h0000_0010)) begin
            n_fail++; $display("FAIL flush_line0_valid: hit=%b inst=%h want 1/%h", hit, inst, exp_inst(32'h10));
        end
        fetch_pc = 32'h0000_0100;
        @(negedge clk);
        n_tests++;
        if (mem_en !== 1'b1) begin
            n_fail++; $display("FAIL flush_next_fill: mem_en=%b want 1", mem_en);
        end
        serve_fill("flush_new");
        fetch_en = 1'b0;
        @(negedge clk);
        n_tests++;
        if (hit !== 1'b1 || inst !== exp_inst(32'h0000_0100)) begin
            n_fail++; $display("FAIL flush_new_hit: hit=%b inst=%h want 1/%h", hit, inst, exp_inst(32'h100));
        end
    endtask

    task automatic test_rdy_stall();
        logic [31:0] exp_pc;
        fetch_en = 1'b1; fetch_pc = 32'h0000_1044;
        exp_fill_q.push_back(32'h0000_1040);
        wait_mem_en("stall");
        exp_pc = exp_fill_q.pop_front();
        rdy = 1'b0; mem_data = line_of(exp_pc); mem_done = 1'b1;
        fetch_pc = 32'h0000_2000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++;
            if (mem_en !== 1'b1 || mem_pc !== exp_pc) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: mem_en=%b mem_pc=%h want 1/%h", i, mem_en, mem_pc, exp_pc);
            end
        end
        fetch_pc = 32'h0000_1044;
        #1;
        n_tests++;
        if (hit !== 1'b0) begin
            n_fail++; $display("FAIL stall_no_capture: hit=%b want 0", hit);
        end
        rdy = 1'b1;
        @(posedge clk);
        #1 mem_done = 1'b0; fetch_en = 1'b0;
        @(negedge clk);
        n_tests++;
        if (hit !== 1'b1 || inst !== exp_inst(32'h0000_1044) || mem_en !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release: hit=%b inst=%h mem_en=%b want 1/%h/0", hit, inst, mem_en, exp_inst(32'h1044));
        end
    endtask

    task automatic test_reset_mid_fill();
        logic [31:0] probe [5];
        probe = '{32'h0, 32'h100, 32'h400, 32'h1040, 32'h3000};
        fetch_en = 1'b1; fetch_pc = 32'h0000_3000;
        exp_fill_q.push_back(32'h0000_3000);
        wait_mem_en("rst_mid");
        void'(exp_fill_q.pop_front());
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0; fetch_en = 1'b0;
        @(negedge clk);
        n_tests++;
        if (mem_en !== 1'b0 || mem_pc !== 32'h0) begin
            n_fail++; $display("FAIL rst_mid_outputs: mem_en=%b mem_pc=%h want 0/0", mem_en, mem_pc);
        end
        mem_data = line_of(32'h0000_3000); mem_done = 1'b1;
        @(posedge clk);
        #1 mem_done = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            fetch_pc = probe[i];
            #1;
            n_tests++;
            if (hit !== 1'b0) begin
                n_fail++; $display("FAIL rst_mid_invalid_%h: hit=%b want 0", probe[i], hit);
            end
        end
        n_tests++;
        if (mem_en !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_done_ignored: mem_en=%b want 0", mem_en);
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_same_line_hit();
        test_conflict();
        test_flush();
        test_rdy_stall();
        test_reset_mid_fill();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1, "watchdog expired");
    end
endmodule
